// File: rtl/crc_ctrl_pkg.sv
// Shared types and constants for the CRC controller and its LFSR engine.
// Holds the controller state enum and the standard CRC32 polynomial/seed.
package crc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [31:0] CRC32_POLY = 32'h04c11db7;
    localparam logic [31:0] CRC32_INIT = 32'hffffffff;

endpackage

// File: rtl/lfsr_crc.sv
// Byte-wide LFSR/CRC engine: advances DATA_WIDTH bits per valid cycle,
// with a load port for seeding and a registered, optionally inverted, output.
module lfsr_crc #(
    parameter int                     LFSR_WIDTH  = 32,
    parameter logic [LFSR_WIDTH-1:0]  LFSR_POLY   = 32'h04c11db7,
    parameter string                  LFSR_CONFIG = "GALOIS",
    parameter logic [LFSR_WIDTH-1:0]  LFSR_INIT   = '1,
    parameter bit                     REVERSE     = 1'b1,
    parameter bit                     INVERT      = 1'b1,
    parameter int                     DATA_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_in_valid,
    input  logic                   set_state,
    input  logic [LFSR_WIDTH-1:0]  state_in,
    output logic [LFSR_WIDTH-1:0]  data_out
);

    function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
        logic [LFSR_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < LFSR_WIDTH; k++) begin
            r[k] = v[LFSR_WIDTH-1-k];
        end
        return r;
    endfunction

    localparam bit                    IS_GALOIS = (LFSR_CONFIG == "GALOIS");
    localparam logic [LFSR_WIDTH-1:0] POLY_REV  = reflect(LFSR_POLY);
    localparam logic [LFSR_WIDTH-1:0] OUT_MASK  = INVERT ? {LFSR_WIDTH{1'b1}} : {LFSR_WIDTH{1'b0}};

    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic                  bit_in;
    logic                  fb;

    // Reflected mode shifts right against the bit-reversed polynomial so the
    // register never needs reflecting on the way in or out.
    always_comb begin
        lfsr_next = lfsr_state;
        bit_in    = 1'b0;
        fb        = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            bit_in = REVERSE ? data_in[i] : data_in[DATA_WIDTH-1-i];
            if (IS_GALOIS) begin
                if (REVERSE) begin
                    fb        = lfsr_next[0] ^ bit_in;
                    lfsr_next = lfsr_next >> 1;
                    if (fb) lfsr_next = lfsr_next ^ POLY_REV;
                end else begin
                    fb        = lfsr_next[LFSR_WIDTH-1] ^ bit_in;
                    lfsr_next = lfsr_next << 1;
                    if (fb) lfsr_next = lfsr_next ^ LFSR_POLY;
                end
            end else begin
                fb        = (^(lfsr_next & LFSR_POLY)) ^ bit_in;
                lfsr_next = {lfsr_next[LFSR_WIDTH-2:0], fb};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_state <= LFSR_INIT;
        end else if (set_state) begin
            lfsr_state <= state_in;
        end else if (data_in_valid) begin
            lfsr_state <= lfsr_next;
        end
    end

    assign data_out = lfsr_state ^ OUT_MASK;

endmodule

// File: rtl/crc_ctrl.sv
// Word-to-byte CRC controller: accepts 1..4 byte words, feeds the engine a
// byte per cycle, and publishes the frame CRC with a one-cycle strobe.
module crc_ctrl
    import crc_ctrl_pkg::*;
#(
    parameter int                    CRC_WIDTH = 32,
    parameter logic [CRC_WIDTH-1:0]  CRC_POLY  = CRC32_POLY,
    parameter logic [CRC_WIDTH-1:0]  CRC_INIT  = '1,
    parameter bit                    REVERSE   = 1'b1,
    parameter bit                    INVERT    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_valid,
    input  logic [CRC_WIDTH-1:0]  seed_val,
    input  logic [31:0]           s_data,
    input  logic [1:0]            s_bytes,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [CRC_WIDTH-1:0]  crc_out,
    output logic                  crc_valid,
    output logic                  busy
);

    state_t                 state, next_state;
    logic [31:0]            cap_data;
    logic [1:0]             cap_bytes;
    logic                   cap_last;
    logic [1:0]             byte_idx;
    logic                   accept;

    logic [7:0]             eng_data;
    logic                   eng_valid;
    logic                   eng_set;
    logic [CRC_WIDTH-1:0]   eng_state_in;
    logic [CRC_WIDTH-1:0]   eng_out;

    assign s_ready = (state == IDLE) & ~seed_valid;
    assign busy    = (state != IDLE);
    assign accept  = s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Seed loads only from IDLE; FINISH re-arms the engine for the next frame.
    always_comb begin
        next_state   = state;
        eng_valid    = 1'b0;
        eng_set      = 1'b0;
        eng_state_in = CRC_INIT;
        eng_data     = cap_data[{byte_idx, 3'b000} +: 8];
        case (state)
            IDLE: begin
                if (seed_valid) begin
                    eng_set      = 1'b1;
                    eng_state_in = seed_val;
                end else if (s_valid) begin
                    next_state = FEED;
                end
            end
            FEED: begin
                eng_valid = 1'b1;
                if (byte_idx == cap_bytes) begin
                    next_state = cap_last ? FINISH : IDLE;
                end
            end
            FINISH: begin
                eng_set      = 1'b1;
                eng_state_in = CRC_INIT;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_data  <= '0;
            cap_bytes <= '0;
            cap_last  <= 1'b0;
            byte_idx  <= '0;
            crc_out   <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= (state == FINISH);
            if (state == FINISH) begin
                crc_out <= eng_out;
            end
            if (accept) begin
                cap_data  <= s_data;
                cap_bytes <= s_bytes;
                cap_last  <= s_last;
                byte_idx  <= 2'd0;
            end else if (state == FEED) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    lfsr_crc #(
        .LFSR_WIDTH  (CRC_WIDTH),
        .LFSR_POLY   (CRC_POLY),
        .LFSR_CONFIG ("GALOIS"),
        .LFSR_INIT   (CRC_INIT),
        .REVERSE     (REVERSE),
        .INVERT      (INVERT),
        .DATA_WIDTH  (8)
    ) u_lfsr_crc (
        .clk           (clk),
        .rst           (rst),
        .data_in       (eng_data),
        .data_in_valid (eng_valid),
        .set_state     (eng_set),
        .state_in      (eng_state_in),
        .data_out      (eng_out)
    );

endmodule

// File: doc/crc_ctrl.md
CRC_CTRL -- requirements
Module: crc_ctrl

Interface
REQ-001 Parameters SHALL be:
  CRC_WIDTH, 32, CRC register width.
  CRC_POLY, 32'h04c11db7, generator polynomial (top term implicit).
  CRC_INIT, all ones, default frame seed.
  REVERSE, 1, LSB-first bit order.
  INVERT, 1, invert the result.
REQ-002 Ports SHALL be:
  clk  in  1  single clock.
  rst  in  1  synchronous, active-high reset.
  seed_valid  in  1  load seed_val as the current-frame state.
  seed_val  in  CRC_WIDTH  seed value.
  s_data  in  32  data word; byte 0 = s_data[7:0].
  s_bytes  in  2  valid bytes minus one (0..3).
  s_last  in  1  word ends the frame.
  s_valid  in  1  word offered.
  s_ready  out  1  word accepted when s_valid & s_ready.
  crc_out  out  CRC_WIDTH  last completed frame CRC.
  crc_valid  out  1  one-cycle result strobe.
  busy  out  1  high whenever state != IDLE.

Function
REQ-003 FSM states SHALL be IDLE, FEED and FINISH.
REQ-004 s_ready SHALL equal (state==IDLE) & ~seed_valid.
REQ-005 In IDLE, seed_valid SHALL drive engine set_state with seed_val that cycle and SHALL win over a simultaneous s_valid.
REQ-006 seed_valid outside IDLE SHALL be ignored.
REQ-007 On handshake, the controller SHALL capture s_data, s_bytes and s_last, and go to FEED with byte index 0.
REQ-008 FEED SHALL present one byte per cycle to the engine with data_in_valid=1, in ascending byte index order.
REQ-009 After byte s_bytes, FEED SHALL go to FINISH if the captured last flag is set, else to IDLE.
REQ-010 Bytes above s_bytes SHALL never reach the engine.
REQ-011 FINISH SHALL last one cycle and, in that cycle:
  - latch the engine output into the result register;
  - pulse engine set_state with CRC_INIT;
  - return to IDLE.
REQ-012 crc_valid SHALL be high for exactly the cycle after FINISH, with crc_out already updated.
REQ-013 crc_out SHALL hold its value until the next FINISH.
REQ-014 Latency: for a last word of n bytes handshaken in cycle 0, FEED SHALL occupy cycles 1..n, FINISH cycle n+1, crc_valid cycle n+2.
REQ-015 A seed loaded in IDLE SHALL apply only to the frame that follows; every later frame SHALL start from CRC_INIT unless re-seeded.
REQ-016 Non-last words SHALL accumulate into the frame with no result strobe.
REQ-017 A frame with no seed load SHALL start from CRC_INIT.
REQ-018 Engine data_in_valid SHALL be 0 in every cycle outside FEED.

Reset
REQ-019 rst SHALL force the following, regardless of state (including mid-frame, discarding the partial frame):
  - state IDLE;
  - crc_out 0, crc_valid 0, busy 0;
  - engine reset to CRC_INIT.
REQ-020 s_ready SHALL be 1 in the first cycle after rst deasserts (if seed_valid=0).

Structure
REQ-021 A shared package SHALL hold:
  - the state enum {IDLE, FEED, FINISH};
  - CRC32 constants (poly 32'h04c11db7, init 32'hffffffff).
REQ-022 The controller SHALL instantiate exactly one sub-module, lfsr_crc, with:
  - LFSR_WIDTH=CRC_WIDTH, DATA_WIDTH=8, LFSR_CONFIG "GALOIS";
  - LFSR_POLY, LFSR_INIT, REVERSE and INVERT passed through from CRC_POLY, CRC_INIT, REVERSE and INVERT.
REQ-023 All controller outputs SHALL be registered or decoded directly from the state register.

Verification
REQ-024 Bench SHALL cover CRC32 check value: words 0x34333231/3, 0x38373635/3, 0x00000039/0 (s_last on third) -> crc_out 0xCBF43926, one crc_valid pulse.
REQ-025 Bench SHALL cover single-byte frame: s_data 0x00, s_bytes 0, s_last 1 in cycle 0 -> FEED cycle 1, FINISH cycle 2, crc_valid cycle 3, crc_out 0xD202EF8D.
REQ-026 Bench SHALL cover back-to-back frames: REQ-024 frame twice -> both results 0xCBF43926, confirming auto re-init.
REQ-027 Bench SHALL cover seed/data collision: seed_valid=1 and s_valid=1 in the same IDLE cycle -> s_ready 0, seed loaded, word accepted next cycle.
REQ-028 Bench SHALL cover reset mid-frame: rst during the second FEED byte, then the REQ-025 frame -> crc_out 0xD202EF8D, no stale strobe.
REQ-029 Bench SHALL cover stability: crc_out unchanged while non-last words stream, and s_ready 0 throughout FEED/FINISH.
